// File: rtl/fetch_sequencer.sv
// fetch_sequencer: six-state one-hot ring that fetches one instruction per pass.
// Optional macro FETCH_STALL_EN: T3 waits on mem_ready before loading ir.
// Ports:
//   clk, rst (async, active-high)
//   run        start next instruction from T1
//   pc_count   current program counter
//   mem_data   instruction ROM read data (combinational)
//   mem_ready  read data valid (only with FETCH_STALL_EN)
//   pc_enable  PC increment strobe (T2)
//   mem_addr   memory address register
//   mem_rd     read strobe (T3)
//   ir         instruction register; opcode = ir[7:4], operand = ir[3:0]
//   ir_valid   new instruction in ir (T4)
//   t_state    one-hot ring state, bit0 = T1 .. bit5 = T6
//   halted     sticky halt flag
module fetch_sequencer #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter logic [3:0] HLT_OPCODE = 4'hF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [ADDR_W-1:0] pc_count,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_ready,
    output logic              pc_enable,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic [DATA_W-1:0] ir,
    output logic [3:0]        opcode,
    output logic [3:0]        operand,
    output logic              ir_valid,
    output logic [5:0]        t_state,
    output logic              halted
);

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    logic [5:0] state_nx;
    logic       mar_ld;
    logic       ir_ld;
    logic       halt_set;
    logic       fetch_done;

`ifdef FETCH_STALL_EN
    assign fetch_done = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign fetch_done = 1'b1;
`endif

    // State register plus the datapath registers it controls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_state  <= T1;
            mem_addr <= '0;
            ir       <= '0;
            halted   <= 1'b0;
        end else begin
            t_state <= state_nx;
            if (mar_ld)   mem_addr <= pc_count;
            if (ir_ld)    ir       <= mem_data;
            if (halt_set) halted   <= 1'b1;
        end
    end

    // Next state; any non-one-hot value falls back to T1.
    always_comb begin
        state_nx = T1;
        case (t_state)
            T1:      state_nx = (run && !halted) ? T2 : T1;
            T2:      state_nx = T3;
            T3:      state_nx = fetch_done ? T4 : T3;
            T4:      state_nx = T5;
            T5:      state_nx = T6;
            T6:      state_nx = T1;
            default: state_nx = T1;
        endcase
    end

    // Strobes are decoded from exact state values only.
    always_comb begin
        pc_enable = 1'b0;
        mem_rd    = 1'b0;
        ir_valid  = 1'b0;
        mar_ld    = 1'b0;
        ir_ld     = 1'b0;
        halt_set  = 1'b0;
        case (t_state)
            T1: mar_ld = run && !halted;
            T2: pc_enable = 1'b1;
            T3: begin
                mem_rd = 1'b1;
                ir_ld  = fetch_done;
            end
            T4: begin
                ir_valid = 1'b1;
                halt_set = (ir[7:4] == HLT_OPCODE);
            end
            default: ;
        endcase
    end

    assign opcode  = ir[7:4];
    assign operand = ir[3:0];

endmodule
